// File: rtl/regfile_wb_arbiter.sv
// Purpose : arbitrates ALU and load writebacks onto one register-file write port, tracks pending
//           destinations in a scoreboard, and raises an issue stall on RAW/WAW hazards.
// Latency : 1 cycle from an accepted handshake to RegWrite/wr_rd/wr_data; ready is combinational.
// Backpressure: at most one requester is granted per cycle. The loser keeps valid high and retries.
//           Both readies are low during reset.
// Ports   : clk, rst (sync, active-high)
//           a_valid/a_ready/a_rd/a_data  - ALU writeback request
//           m_valid/m_ready/m_rd/m_data  - load / multicycle writeback request
//           RegWrite/wr_rd/wr_data       - register-file write port (registered)
//           iss_valid/iss_rd/rs1/rs2     - decode issue and source indices
//           stall                        - issue hazard
//           byp1_hit/byp2_hit/byp1_data/byp2_data - forwarding from the write port
// Config  : define RF_WB_BYPASS_EN to forward the write-port value to rs1/rs2. Without it, the
//           forwarding outputs are tied to 0 and a source still stalls in its write cycle.
module regfile_wb_arbiter #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [AW-1:0]    a_rd,
  input  logic [WIDTH-1:0] a_data,
  input  logic             m_valid,
  output logic             m_ready,
  input  logic [AW-1:0]    m_rd,
  input  logic [WIDTH-1:0] m_data,
  output logic             RegWrite,
  output logic [AW-1:0]    wr_rd,
  output logic [WIDTH-1:0] wr_data,
  input  logic             iss_valid,
  input  logic [AW-1:0]    iss_rd,
  input  logic [AW-1:0]    rs1,
  input  logic [AW-1:0]    rs2,
  output logic             stall,
  output logic             byp1_hit,
  output logic             byp2_hit,
  output logic [WIDTH-1:0] byp1_data,
  output logic [WIDTH-1:0] byp2_data
);

  // Round-robin pointer: 0 means the ALU wins the next contested cycle.
  logic             ptr_q, ptr_d;
  logic             regwrite_q, regwrite_d;
  logic [AW-1:0]    wr_rd_q, wr_rd_d;
  logic [WIDTH-1:0] wr_data_q, wr_data_d;
  logic [DEPTH-1:0] pending_q, pending_d;

  logic             contest;
  logic             grant_a, grant_m;
  logic [DEPTH-1:0] clr_mask;
  logic [DEPTH-1:0] pend_eff;
  logic             issue_ok;

  // ---------------------------------------------------------------- arbitration
  always_comb begin
    contest = 1'b0;
    grant_a = 1'b0;
    grant_m = 1'b0;
    if (!rst) begin
      contest = a_valid && m_valid;
      if (contest) begin
        grant_a = !ptr_q;
        grant_m = ptr_q;
      end else begin
        grant_a = a_valid;
        grant_m = m_valid;
      end
    end
  end

  // The pointer moves only when both requested. An uncontested grant leaves the preference alone.
  always_comb begin
    ptr_d = ptr_q;
    if (contest) begin
      ptr_d = ~ptr_q;
    end
  end

  assign a_ready = grant_a;
  assign m_ready = grant_m;

  // ---------------------------------------------------------------- write port
  // An x0 write is still consumed and recorded, but it must never reach the register file.
  // When nothing is accepted, the destination and data hold their previous values.
  always_comb begin
    regwrite_d = 1'b0;
    wr_rd_d    = wr_rd_q;
    wr_data_d  = wr_data_q;
    if (grant_a) begin
      regwrite_d = (a_rd != '0);
      wr_rd_d    = a_rd;
      wr_data_d  = a_data;
    end else if (grant_m) begin
      regwrite_d = (m_rd != '0);
      wr_rd_d    = m_rd;
      wr_data_d  = m_data;
    end
  end

  assign RegWrite = regwrite_q;
  assign wr_rd    = wr_rd_q;
  assign wr_data  = wr_data_q;

  // ---------------------------------------------------------------- scoreboard
  always_comb begin
    clr_mask = '0;
    if (regwrite_q) begin
      clr_mask[wr_rd_q] = 1'b1;
    end
  end

  // With forwarding, a register being written this cycle is no longer a hazard. Its value is
  // available on the bypass outputs.
  always_comb begin
`ifdef RF_WB_BYPASS_EN
    pend_eff = pending_q & ~clr_mask;
`else
    pend_eff = pending_q;
`endif
    pend_eff[0] = 1'b0;
  end

  assign stall    = !rst && iss_valid && (pend_eff[rs1] || pend_eff[rs2] || pend_eff[iss_rd]);
  assign issue_ok = iss_valid && !stall && (iss_rd != '0);

  // Apply the clear first and the set second, so an issue to the register being written
  // leaves it pending.
  always_comb begin
    pending_d = pending_q & ~clr_mask;
    if (issue_ok) begin
      pending_d[iss_rd] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  // ---------------------------------------------------------------- forwarding
`ifdef RF_WB_BYPASS_EN
  assign byp1_hit  = regwrite_q && (wr_rd_q == rs1);
  assign byp2_hit  = regwrite_q && (wr_rd_q == rs2);
  assign byp1_data = wr_data_q;
  assign byp2_data = wr_data_q;
`else
  assign byp1_hit  = 1'b0;
  assign byp2_hit  = 1'b0;
  assign byp1_data = '0;
  assign byp2_data = '0;
`endif

  // ---------------------------------------------------------------- state
  // Reset also drops a transfer that was accepted but not yet written.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= 1'b0;
      regwrite_q <= 1'b0;
      wr_rd_q    <= '0;
      wr_data_q  <= '0;
      pending_q  <= '0;
    end else begin
      ptr_q      <= ptr_d;
      regwrite_q <= regwrite_d;
      wr_rd_q    <= wr_rd_d;
      wr_data_q  <= wr_data_d;
      pending_q  <= pending_d;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;
  localparam int WIDTH = 32;
  localparam int DEPTH = 32;
  localparam int AW    = 5;
`ifdef RF_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             a_valid, a_ready, m_valid, m_ready;
  logic [AW-1:0]    a_rd, m_rd, wr_rd, iss_rd, rs1, rs2;
  logic [WIDTH-1:0] a_data, m_data, wr_data, byp1_data, byp2_data;
  logic             RegWrite, iss_valid, stall, byp1_hit, byp2_hit;

  regfile_wb_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_rd(m_rd), .m_data(m_data),
    .RegWrite(RegWrite), .wr_rd(wr_rd), .wr_data(wr_data),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .rs1(rs1), .rs2(rs2),
    .stall(stall),
    .byp1_hit(byp1_hit), .byp2_hit(byp2_hit), .byp1_data(byp1_data), .byp2_data(byp2_data)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: who is preferred on a conflict, the last write, and a set of busy registers.
  bit               alu_turn = 1'b1;
  bit               mdl_rw   = 1'b0;
  logic [AW-1:0]    mdl_wr_rd   = '0;
  logic [WIDTH-1:0] mdl_wr_data = '0;
  bit               pend[DEPTH];

  function automatic bit busy(input logic [AW-1:0] r);
    if (r == 0) return 1'b0;
    if (BYP && mdl_rw && mdl_wr_rd == r) return 1'b0;
    return pend[r];
  endfunction

  function automatic bit exp_a_ready();
    return !rst && a_valid && (!m_valid || alu_turn);
  endfunction

  function automatic bit exp_m_ready();
    return !rst && m_valid && (!a_valid || !alu_turn);
  endfunction

  function automatic bit exp_stall();
    return !rst && iss_valid && (busy(rs1) || busy(rs2) || busy(iss_rd));
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    bit hit1, hit2;
    hit1 = BYP && mdl_rw && (mdl_wr_rd == rs1);
    hit2 = BYP && mdl_rw && (mdl_wr_rd == rs2);
    chk("a_ready",   a_ready,   exp_a_ready());
    chk("m_ready",   m_ready,   exp_m_ready());
    chk("RegWrite",  RegWrite,  mdl_rw);
    chk("wr_rd",     wr_rd,     mdl_wr_rd);
    chk("wr_data",   wr_data,   mdl_wr_data);
    chk("stall",     stall,     exp_stall());
    chk("byp1_hit",  byp1_hit,  hit1);
    chk("byp2_hit",  byp2_hit,  hit2);
    chk("byp1_data", byp1_data, BYP ? mdl_wr_data : '0);
    chk("byp2_data", byp2_data, BYP ? mdl_wr_data : '0);
  endtask

  // Inputs change on the falling edge. Outputs are checked 1 ns later.
  task automatic settle();
    #1;
    compare_all();
  endtask

  task automatic advance();
    bit ga, gm, st;
    ga = exp_a_ready();
    gm = exp_m_ready();
    st = exp_stall();
    @(posedge clk);
    if (rst) begin
      foreach (pend[i]) pend[i] = 1'b0;
      alu_turn    = 1'b1;
      mdl_rw      = 1'b0;
      mdl_wr_rd   = '0;
      mdl_wr_data = '0;
    end else begin
      if (mdl_rw) pend[mdl_wr_rd] = 1'b0;
      if (iss_valid && !st && iss_rd != 0) pend[iss_rd] = 1'b1;
      if (a_valid && m_valid) alu_turn = !alu_turn;
      if (ga) begin
        mdl_rw = (a_rd != 0); mdl_wr_rd = a_rd; mdl_wr_data = a_data;
      end else if (gm) begin
        mdl_rw = (m_rd != 0); mdl_wr_rd = m_rd; mdl_wr_data = m_data;
      end else begin
        mdl_rw = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle();
    a_valid = 0; a_rd = 0; a_data = 0;
    m_valid = 0; m_rd = 0; m_data = 0;
    iss_valid = 0; iss_rd = 0; rs1 = 0; rs2 = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    a_valid = 1; a_rd = 3; m_valid = 1; m_rd = 4; iss_valid = 1; iss_rd = 2;
    settle();
    chk("rst_a_ready", a_ready, 1'b0);
    chk("rst_m_ready", m_ready, 1'b0);
    chk("rst_stall",   stall,   1'b0);
    advance();
    rst = 1'b0;
    idle();
  endtask

  initial begin
    foreach (pend[i]) pend[i] = 1'b0;
    rst = 1'b1;
    idle();
    @(posedge clk);
    @(negedge clk);
    do_reset();
    settle();
    chk("reset_RegWrite", RegWrite, 1'b0);
    chk("reset_wr_rd",    wr_rd,    5'd0);
    chk("reset_wr_data",  wr_data,  32'd0);
    advance();

    // Single ALU write
    a_valid = 1; a_rd = 5; a_data = 32'hDEAD_BEEF;
    settle(); chk("alu_ready", a_ready, 1'b1);
    advance(); idle();
    settle();
    chk("alu_wb_RegWrite", RegWrite, 1'b1);
    chk("alu_wb_rd",       wr_rd,    5'd5);
    chk("alu_wb_data",     wr_data,  32'hDEAD_BEEF);
    advance();

    // Contested grants after reset alternate A, M, A, M
    do_reset();
    a_valid = 1; a_rd = 1; a_data = 32'hA;
    m_valid = 1; m_rd = 2; m_data = 32'hB;
    settle(); chk("rr0_a", a_ready, 1'b1); chk("rr0_m", m_ready, 1'b0);
    advance();
    settle(); chk("rr1_m", m_ready, 1'b1); chk("rr1_wr", wr_rd, 5'd1); chk("rr1_rw", RegWrite, 1'b1);
    advance();
    settle(); chk("rr2_a", a_ready, 1'b1); chk("rr2_wr", wr_rd, 5'd2);
    advance();
    settle(); chk("rr3_m", m_ready, 1'b1); chk("rr3_wr", wr_rd, 5'd1);
    advance(); idle();
    settle(); chk("rr4_wr", wr_rd, 5'd2); chk("rr4_rw", RegWrite, 1'b1);
    advance();

    // x0 write is accepted but never written
    m_valid = 1; m_rd = 0; m_data = 32'h1234;
    settle(); chk("x0_ready", m_ready, 1'b1);
    advance(); idle();
    settle(); chk("x0_RegWrite", RegWrite, 1'b0);
    advance();

    // RAW hazard on x7
    do_reset();
    iss_valid = 1; iss_rd = 7;
    settle(); chk("x7_issue_stall", stall, 1'b0);
    advance();
    iss_rd = 3; rs1 = 7;
    settle(); chk("x7_raw_stall", stall, 1'b1);
    advance();
    a_valid = 1; a_rd = 7; a_data = 32'h77;
    settle(); chk("x7_wait_stall", stall, 1'b1);
    advance(); a_valid = 0;
    settle();
    chk("x7_wb_stall", stall,    BYP ? 1'b0 : 1'b1);
    chk("x7_wb_hit",   byp1_hit, BYP ? 1'b1 : 1'b0);
    advance();
    iss_rd = 0;
    settle(); chk("x7_after_stall", stall, 1'b0);
    advance(); idle();

    // Set wins over clear on x9
    do_reset();
    a_valid = 1; a_rd = 9; a_data = 32'h99;
    settle(); advance(); idle();
    iss_valid = 1; iss_rd = 9;
    settle(); chk("x9_set_stall", stall, 1'b0);
    advance();
    iss_rd = 0; rs1 = 9;
    settle(); chk("x9_still_pending", stall, 1'b1);
    advance(); idle();

    // Reset the cycle after an acceptance
    do_reset();
    a_valid = 1; a_rd = 4; a_data = 32'h44; m_valid = 1; m_rd = 6; m_data = 32'h66;
    iss_valid = 1; iss_rd = 5;
    settle(); chk("rstmid_a", a_ready, 1'b1);
    advance();
    do_reset();
    a_valid = 1; a_rd = 1; m_valid = 1; m_rd = 2; iss_valid = 1; rs1 = 5;
    settle();
    chk("rstmid_RegWrite", RegWrite, 1'b0);
    chk("rstmid_ptr",      a_ready,  1'b1);
    chk("rstmid_pending",  stall,    1'b0);
    advance(); idle();

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rst       = ($urandom_range(0, 59) == 0);
      a_valid   = $urandom_range(0, 1);
      m_valid   = $urandom_range(0, 1);
      a_rd      = AW'($urandom_range(0, 7));
      m_rd      = AW'($urandom_range(0, 7));
      a_data    = $urandom;
      m_data    = $urandom;
      iss_valid = $urandom_range(0, 1);
      iss_rd    = AW'($urandom_range(0, 7));
      rs1       = AW'($urandom_range(0, 7));
      rs2       = AW'($urandom_range(0, 7));
      settle();
      advance();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
